// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//
// Shared definitions for the arbiter's downstream consumers.
//
// Contents:
//   MAX_N / IDX_MAX_W  - widest grant vector the helper functions accept
//   seq_state_t        - grant sequencer state encoding
//   onehot_to_idx()    - bit position of the lowest set bit of a vector
//   is_onehot()        - true when exactly one bit of a vector is set
// ---------------------------------------------------------------------------
package arb_pkg;

  // The helpers work on a fixed-width vector so that any requester count
  // up to MAX_N can share them. Callers zero-extend narrower grant vectors.
  localparam int MAX_N     = 32;
  localparam int IDX_MAX_W = $clog2(MAX_N);

  // Sequencer states. The encoding is fixed so that the state is easy to
  // recognise on a waveform.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } seq_state_t;

  // Position of the lowest set bit. The scan runs from the top down so the
  // last assignment made is the lowest position. For a true one-hot input
  // this is simply the position of the single set bit. Returns 0 when no
  // bit is set, so callers must qualify the result with is_onehot().
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(
    input logic [MAX_N-1:0] vec
  );
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i[IDX_MAX_W-1:0];
      end
    end
    return idx;
  endfunction

  // True when exactly one bit is set. Zero and multi-hot both return 0.
  function automatic logic is_onehot(
    input logic [MAX_N-1:0] vec
  );
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (vec[i]) begin
        ones++;
      end
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// ---------------------------------------------------------------------------
// onehot_enc
//
// Turns an N-bit grant vector into a requester index and classifies it.
//
// Parameters:
//   N   - width of the one-hot vector (2..MAX_N)
//   IW  - width of the encoded index
//
// Ports:
//   i_onehot  in   N   vector to encode
//   o_idx     out  IW  position of the set bit (lowest set bit if multi-hot)
//   o_valid   out  1   exactly one bit set
//   o_multi   out  1   more than one bit set
// ---------------------------------------------------------------------------
module onehot_enc
  import arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid,
  output logic          o_multi
);

  logic [MAX_N-1:0] w_paddedVec;

  // Widen to the package helper width; the upper bits are always zero.
  assign w_paddedVec = MAX_N'(i_onehot);

  // Index and classification are pure combinational decode. A vector that
  // has bits set but is not one-hot is, by elimination, multi-hot.
  assign o_idx   = IW'(onehot_to_idx(w_paddedVec));
  assign o_valid = is_onehot(w_paddedVec);
  assign o_multi = (|i_onehot) & ~o_valid;

endmodule

// File: rtl/arb_grant_sequencer.sv
// ---------------------------------------------------------------------------
// arb_grant_sequencer
//
// Takes the arbiter's one-hot grant, latches the winner and drives that
// requester's burst onto a shared valid/ready bus. A completed burst is
// answered with a one-cycle o_ack_out pulse, followed by one quiet cycle
// so that the arbiter always sees a falling edge on its ack input.
//
// Parameters:
//   N   - number of requesters (>= 2, matches the arbiter)
//   DW  - data width per requester and of the bus
//   LW  - burst length field width; a burst is len+1 beats
//
// Ports:
//   i_clk          in   1     rising-edge clock
//   i_rst_n        in   1     asynchronous active-low reset
//   i_grant        in   N     one-hot grant from the arbiter, 0 = no winner
//   i_req_data     in   N*DW  per-requester current beat, slice i*DW +: DW
//   i_req_len      in   N*LW  per-requester burst length - 1
//   o_bus_valid    out  1     beat valid
//   o_bus_data     out  DW    beat data
//   o_bus_src      out  IW    index of the requester owning the burst
//   o_bus_last     out  1     final beat of the burst
//   i_bus_ready    in   1     target accepts the beat
//   o_beat_taken   out  N     one-hot, beat of requester i accepted
//   o_done         out  N     one-hot pulse, burst of requester i finished
//   o_ack_out      out  1     one-cycle pulse per completed burst
//   o_busy         out  1     sequencer is not idle
//   o_grant_err    out  1     one-cycle pulse, multi-hot grant seen in IDLE
// ---------------------------------------------------------------------------
module arb_grant_sequencer
  import arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int LW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_grant,
  input  logic [N*DW-1:0] i_req_data,
  input  logic [N*LW-1:0] i_req_len,
  output logic            o_bus_valid,
  output logic [DW-1:0]   o_bus_data,
  output logic [IW-1:0]   o_bus_src,
  output logic            o_bus_last,
  input  logic            i_bus_ready,
  output logic [N-1:0]    o_beat_taken,
  output logic [N-1:0]    o_done,
  output logic            o_ack_out,
  output logic            o_busy,
  output logic            o_grant_err
);

  seq_state_t    r_state;
  logic [IW-1:0] r_idx;
  logic [LW-1:0] r_lenQ;
  logic [LW-1:0] r_beatCnt;
  logic          r_busValid;
  logic          r_ackOut;
  logic [N-1:0]  r_done;
  logic          r_grantErr;

  logic [IW-1:0] w_grantIdx;
  logic          w_grantValid;
  logic          w_grantMulti;
  logic          w_beatAccept;
  logic          w_lastBeat;
  logic [N-1:0]  w_idxOneHot;

  // Decode the incoming grant. Only consulted while idle; later changes of
  // the grant cannot disturb a burst already in progress.
  onehot_enc #(
    .N  (N),
    .IW (IW)
  ) u_grantEnc (
    .i_onehot (i_grant),
    .o_idx    (w_grantIdx),
    .o_valid  (w_grantValid),
    .o_multi  (w_grantMulti)
  );

  // A beat moves when the bus handshake completes; it is the last one when
  // the beat counter has caught up with the latched length.
  assign w_beatAccept = r_busValid & i_bus_ready;
  assign w_lastBeat   = r_busValid & (r_beatCnt == r_lenQ);

  // One-hot form of the latched owner, shared by the beat and done pulses.
  always_comb begin
    w_idxOneHot        = '0;
    w_idxOneHot[r_idx] = 1'b1;
  end

  // Sequencer FSM. Entering XFER latches owner and length so the burst is
  // self-contained. The final accepted beat goes straight to ACK with the
  // ack/done pulses already registered, then GAP forces ack low for a cycle
  // before the grant is looked at again. Reset abandons any burst silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_lenQ     <= '0;
      r_beatCnt  <= '0;
      r_busValid <= 1'b0;
      r_ackOut   <= 1'b0;
      r_done     <= '0;
      r_grantErr <= 1'b0;
    end else begin
      r_ackOut   <= 1'b0;
      r_done     <= '0;
      r_grantErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_idx      <= w_grantIdx;
            r_lenQ     <= i_req_len[w_grantIdx*LW +: LW];
            r_beatCnt  <= '0;
            r_busValid <= 1'b1;
            r_state    <= XFER;
          end else if (w_grantMulti) begin
            r_grantErr <= 1'b1;
          end
        end
        XFER: begin
          if (w_beatAccept) begin
            r_beatCnt <= r_beatCnt + 1'b1;
            if (w_lastBeat) begin
              r_busValid <= 1'b0;
              r_ackOut   <= 1'b1;
              r_done     <= w_idxOneHot;
              r_state    <= ACK;
            end
          end
        end
        ACK: begin
          r_state <= GAP;
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Bus data follows the owner's current beat; it is forced to zero when no
  // beat is offered so the shared bus stays quiet between bursts.
  assign o_bus_valid  = r_busValid;
  assign o_bus_data   = r_busValid ? i_req_data[r_idx*DW +: DW] : '0;
  assign o_bus_src    = r_idx;
  assign o_bus_last   = w_lastBeat;
  assign o_beat_taken = w_beatAccept ? w_idxOneHot : '0;
  assign o_done       = r_done;
  assign o_ack_out    = r_ackOut;
  assign o_busy       = (r_state != IDLE);
  assign o_grant_err  = r_grantErr;

endmodule
